// File: rtl/darkbus_arbiter.sv
// N-master to 1-slave bus switch with registered fixed-priority or round-robin
// arbitration, per-transaction timeout and one-hot completion/error pulses.
module darkbus_arbiter #(
  parameter int NM      = 2,
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int MODE    = 1,
  parameter int TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 res_n,
  input  logic [NM-1:0]        m_en,
  input  logic [NM-1:0]        m_rw,
  input  logic [NM*AW-1:0]     m_addr,
  input  logic [NM*DW-1:0]     m_wdata,
  input  logic [NM*DW/8-1:0]   m_be,
  output logic [DW-1:0]        m_rdata,
  output logic [NM-1:0]        m_valid,
  output logic [NM-1:0]        m_err,
  output logic [NM-1:0]        grant,
  output logic                 busy,
  output logic                 s_en,
  output logic                 s_rw,
  output logic [AW-1:0]        s_addr,
  output logic [DW-1:0]        s_wdata,
  output logic [DW/8-1:0]      s_be,
  input  logic [DW-1:0]        s_rdata,
  input  logic                 s_valid
);

  localparam int BW = DW / 8;
  localparam int PW = (NM > 1) ? $clog2(NM) : 1;
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [CW-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_RELEASE} state_t;

  state_t          r_state, w_state_nxt;
  logic [PW-1:0]   r_ptr;
  logic [CW-1:0]   r_cnt;

  logic [PW-1:0]   w_fp, w_rr_hi, w_win;
  logic            w_hi_hit, w_timeout;
  logic [NM-1:0]   w_onehot;
  logic            w_rw;
  logic [AW-1:0]   w_addr;
  logic [DW-1:0]   w_wdata;
  logic [BW-1:0]   w_be;

  // Round-robin: first requester above the pointer, else wrap to the lowest one.
  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    w_fp     = '0;
    w_rr_hi  = '0;
    w_hi_hit = 1'b0;
    for (int j = NM - 1; j >= 0; j--) begin
      if (m_en[j]) w_fp = PW'(j);
      if (m_en[j] && (PW'(j) > r_ptr)) begin
        w_rr_hi  = PW'(j);
        w_hi_hit = 1'b1;
      end
    end
    w_win = (MODE == 0) ? w_fp : (w_hi_hit ? w_rr_hi : w_fp);
  end

  always_comb begin
    w_onehot = '0;
    w_rw     = 1'b0;
    w_addr   = '0;
    w_wdata  = '0;
    w_be     = '0;
    for (int j = 0; j < NM; j++) begin
      if (PW'(j) == w_win) begin
        w_onehot[j] = 1'b1;
        w_rw        = m_rw[j];
        w_addr      = m_addr[j*AW +: AW];
        w_wdata     = m_wdata[j*DW +: DW];
        w_be        = m_be[j*BW +: BW];
      end
    end
  end

  assign w_timeout = (TIMEOUT != 0) && (r_cnt == CNT_LAST);
  assign busy      = (r_state != ST_IDLE);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:    if (|m_en) w_state_nxt = ST_BUSY;
      ST_BUSY:    if (s_valid || w_timeout) w_state_nxt = ST_RELEASE;
      ST_RELEASE: w_state_nxt = ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      r_state <= ST_IDLE;
      r_ptr   <= PW'(NM - 1);
      r_cnt   <= '0;
      grant   <= '0;
      m_valid <= '0;
      m_err   <= '0;
      m_rdata <= '0;
      s_en    <= 1'b0;
      s_rw    <= 1'b0;
      s_addr  <= '0;
      s_wdata <= '0;
      s_be    <= '0;
    end else begin
      r_state <= w_state_nxt;
      m_valid <= '0;
      m_err   <= '0;
      case (r_state)
        ST_IDLE: begin
          if (|m_en) begin
            grant   <= w_onehot;
            s_en    <= 1'b1;
            s_rw    <= w_rw;
            s_addr  <= w_addr;
            s_wdata <= w_wdata;
            s_be    <= w_be;
            r_ptr   <= w_win;
            r_cnt   <= '0;
          end
        end
        ST_BUSY: begin
          if (r_cnt != CNT_MAX) r_cnt <= r_cnt + 1'b1;
          // A completion on the timeout cycle still counts as a completion.
          if (s_valid) begin
            s_en    <= 1'b0;
            m_valid <= grant;
            if (!s_rw) m_rdata <= s_rdata;
          end else if (w_timeout) begin
            s_en    <= 1'b0;
            m_err   <= grant;
            m_rdata <= '1;
          end
        end
        ST_RELEASE: grant <= '0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_darkbus_arbiter.sv
// Directed bench for darkbus_arbiter: a cycle table for read/write/timeout
// traffic, plus hand sequences for grant ordering and mid-transaction reset.
module tb_darkbus_arbiter;

  localparam logic [31:0] WD0 = 32'hA5A5_A5A5;
  localparam logic [3:0]  BE0 = 4'hF;
  localparam int          NV  = 22;

  logic        clk = 1'b0;
  logic        res_n = 1'b0;
  logic [1:0]  m_en = '0, m_rw = '0;
  logic [63:0] m_addr = '0, m_wdata = '0;
  logic [7:0]  m_be = '0;
  logic [31:0] s_rdata = '0;
  logic        sv_drv = 1'b0, auto_rsp = 1'b0;

  logic [31:0] rr_m_rdata, rr_s_addr, rr_s_wdata;
  logic [1:0]  rr_m_valid, rr_m_err, rr_grant;
  logic        rr_busy, rr_s_en, rr_s_rw, rr_s_valid;
  logic [3:0]  rr_s_be;
  logic [31:0] fp_m_rdata, fp_s_addr, fp_s_wdata;
  logic [1:0]  fp_m_valid, fp_m_err, fp_grant;
  logic        fp_busy, fp_s_en, fp_s_rw, fp_s_valid;
  logic [3:0]  fp_s_be;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign rr_s_valid = sv_drv | (auto_rsp & rr_s_en);
  assign fp_s_valid = auto_rsp & fp_s_en;

  darkbus_arbiter #(.NM(2), .AW(32), .DW(32), .MODE(1), .TIMEOUT(4)) u_rr (
    .clk(clk), .res_n(res_n), .m_en(m_en), .m_rw(m_rw), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_be(m_be), .m_rdata(rr_m_rdata), .m_valid(rr_m_valid),
    .m_err(rr_m_err), .grant(rr_grant), .busy(rr_busy), .s_en(rr_s_en),
    .s_rw(rr_s_rw), .s_addr(rr_s_addr), .s_wdata(rr_s_wdata), .s_be(rr_s_be),
    .s_rdata(s_rdata), .s_valid(rr_s_valid)
  );

  darkbus_arbiter #(.NM(2), .AW(32), .DW(32), .MODE(0), .TIMEOUT(4)) u_fp (
    .clk(clk), .res_n(res_n), .m_en(m_en), .m_rw(m_rw), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_be(m_be), .m_rdata(fp_m_rdata), .m_valid(fp_m_valid),
    .m_err(fp_m_err), .grant(fp_grant), .busy(fp_busy), .s_en(fp_s_en),
    .s_rw(fp_s_rw), .s_addr(fp_s_addr), .s_wdata(fp_s_wdata), .s_be(fp_s_be),
    .s_rdata(s_rdata), .s_valid(fp_s_valid)
  );

  typedef struct {
    logic [1:0]  en, rw;
    logic [31:0] a0, a1, wd1;
    logic [3:0]  be1;
    logic        sv;
    logic [31:0] rd;
    logic [1:0]  x_grant;
    logic        x_sen, x_busy;
    logic [1:0]  x_mv, x_me;
    logic [31:0] x_rdata;
    logic        chk_s, x_rw;
    logic [31:0] x_addr, x_wdata;
    logic [3:0]  x_be;
  } vec_t;

  vec_t vt [NV];

  function automatic vec_t v(logic [1:0] en, logic [1:0] rw, logic [31:0] a0,
                             logic [31:0] a1, logic [31:0] wd1, logic [3:0] be1,
                             logic sv, logic [31:0] rd, logic [1:0] xg, logic xs,
                             logic xb, logic [1:0] xmv, logic [1:0] xme,
                             logic [31:0] xrd, logic chk, logic xrw,
                             logic [31:0] xa, logic [31:0] xwd, logic [3:0] xbe);
    vec_t r;
    r.en = en; r.rw = rw; r.a0 = a0; r.a1 = a1; r.wd1 = wd1; r.be1 = be1;
    r.sv = sv; r.rd = rd; r.x_grant = xg; r.x_sen = xs; r.x_busy = xb;
    r.x_mv = xmv; r.x_me = xme; r.x_rdata = xrd; r.chk_s = chk; r.x_rw = xrw;
    r.x_addr = xa; r.x_wdata = xwd; r.x_be = xbe;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t r);
    m_en    = r.en;
    m_rw    = r.rw;
    m_addr  = {r.a1, r.a0};
    m_wdata = {r.wd1, WD0};
    m_be    = {r.be1, BE0};
    sv_drv  = r.sv;
    s_rdata = r.rd;
  endtask

  logic [1:0] rr_seq [4];
  logic [1:0] fp_seq [4];
  logic [1:0] exp_rr [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
  logic [1:0] rr_prev, fp_prev;
  int nrr, nfp;

  initial begin
    // Read at 0x100, answered on the 3rd BUSY cycle.
    vt[0]  = v(2'b01, 2'b00, 32'h100, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0,
               2'b01, 1'b1, 1'b1, 2'b00, 2'b00, 32'h0, 1'b1, 1'b0, 32'h100, WD0, BE0);
    vt[1]  = vt[0];
    vt[2]  = vt[0];
    vt[3]  = v(2'b01, 2'b00, 32'h100, 32'h0, 32'h0, 4'h0, 1'b1, 32'hCAFE_F00D,
               2'b01, 1'b0, 1'b1, 2'b01, 2'b00, 32'hCAFE_F00D, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    vt[4]  = v(2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0,
               2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 32'hCAFE_F00D, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    // Write from master 1; master inputs change mid-flight, slave side must not.
    vt[5]  = v(2'b10, 2'b10, 32'h0, 32'h200, 32'h1234_5678, 4'h3, 1'b0, 32'h0,
               2'b10, 1'b1, 1'b1, 2'b00, 2'b00, 32'hCAFE_F00D, 1'b1, 1'b1, 32'h200, 32'h1234_5678, 4'h3);
    vt[6]  = v(2'b10, 2'b10, 32'h0, 32'h204, 32'hDEAD_BEEF, 4'hF, 1'b0, 32'h0,
               2'b10, 1'b1, 1'b1, 2'b00, 2'b00, 32'hCAFE_F00D, 1'b1, 1'b1, 32'h200, 32'h1234_5678, 4'h3);
    vt[7]  = v(2'b10, 2'b10, 32'h0, 32'h204, 32'hDEAD_BEEF, 4'hF, 1'b1, 32'h5555_5555,
               2'b10, 1'b0, 1'b1, 2'b10, 2'b00, 32'hCAFE_F00D, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    vt[8]  = vt[4];
    // Silent slave: 4 BUSY cycles then error with all-ones read data.
    vt[9]  = v(2'b01, 2'b00, 32'h300, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0,
               2'b01, 1'b1, 1'b1, 2'b00, 2'b00, 32'hCAFE_F00D, 1'b1, 1'b0, 32'h300, WD0, BE0);
    vt[10] = vt[9];
    vt[11] = vt[9];
    vt[12] = vt[9];
    vt[13] = v(2'b01, 2'b00, 32'h300, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0,
               2'b01, 1'b0, 1'b1, 2'b00, 2'b01, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    vt[14] = v(2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0,
               2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    // Master drops m_en mid-flight; s_valid lands on the timeout cycle.
    vt[15] = v(2'b10, 2'b00, 32'h0, 32'h400, 32'h0, 4'hF, 1'b0, 32'h0,
               2'b10, 1'b1, 1'b1, 2'b00, 2'b00, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'h400, 32'h0, 4'hF);
    vt[16] = v(2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0,
               2'b10, 1'b1, 1'b1, 2'b00, 2'b00, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'h400, 32'h0, 4'hF);
    vt[17] = vt[16];
    vt[18] = vt[16];
    vt[19] = v(2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h0BAD_F00D,
               2'b10, 1'b0, 1'b1, 2'b10, 2'b00, 32'h0BAD_F00D, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    vt[20] = v(2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0,
               2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 32'h0BAD_F00D, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    // Stray s_valid while IDLE must be ignored.
    vt[21] = v(2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h1111_1111,
               2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 32'h0BAD_F00D, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);

    repeat (2) @(negedge clk);
    check("reset grant", rr_grant, 0);
    check("reset s_en", rr_s_en, 0);
    check("reset busy", rr_busy, 0);
    check("reset m_valid", rr_m_valid, 0);
    check("reset m_err", rr_m_err, 0);
    check("reset m_rdata", rr_m_rdata, 0);
    check("reset s_addr", rr_s_addr, 0);
    res_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(vt[i]);
      @(posedge clk);
      #1;
      check($sformatf("row%0d grant", i), rr_grant, vt[i].x_grant);
      check($sformatf("row%0d s_en", i), rr_s_en, vt[i].x_sen);
      check($sformatf("row%0d busy", i), rr_busy, vt[i].x_busy);
      check($sformatf("row%0d m_valid", i), rr_m_valid, vt[i].x_mv);
      check($sformatf("row%0d m_err", i), rr_m_err, vt[i].x_me);
      check($sformatf("row%0d m_rdata", i), rr_m_rdata, vt[i].x_rdata);
      if (vt[i].chk_s) begin
        check($sformatf("row%0d s_rw", i), rr_s_rw, vt[i].x_rw);
        check($sformatf("row%0d s_addr", i), rr_s_addr, vt[i].x_addr);
        check($sformatf("row%0d s_wdata", i), rr_s_wdata, vt[i].x_wdata);
        check($sformatf("row%0d s_be", i), rr_s_be, vt[i].x_be);
      end
    end

    // Grant ordering with both masters requesting and a 1-cycle slave.
    @(negedge clk);
    res_n = 1'b0;
    sv_drv = 1'b0;
    m_en = 2'b00;
    @(negedge clk);
    res_n = 1'b1;
    auto_rsp = 1'b1;
    m_en = 2'b11;
    m_rw = 2'b00;
    rr_prev = '0; fp_prev = '0; nrr = 0; nfp = 0;
    for (int c = 0; c < 16; c++) begin
      @(posedge clk);
      #1;
      if (rr_grant != 2'b00 && rr_prev == 2'b00 && nrr < 4) begin
        rr_seq[nrr] = rr_grant;
        nrr++;
      end
      if (fp_grant != 2'b00 && fp_prev == 2'b00 && nfp < 4) begin
        fp_seq[nfp] = fp_grant;
        nfp++;
      end
      rr_prev = rr_grant;
      fp_prev = fp_grant;
    end
    check("rr grant count", nrr, 4);
    check("fp grant count", nfp, 4);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("rr grant%0d", k), (k < nrr) ? rr_seq[k] : 2'b00, exp_rr[k]);
      check($sformatf("fp grant%0d", k), (k < nfp) ? fp_seq[k] : 2'b00, 2'b01);
    end
    @(negedge clk);
    m_en = 2'b00;
    auto_rsp = 1'b0;
    repeat (8) @(negedge clk);

    // Reset mid-transaction clears everything immediately.
    m_en = 2'b01;
    m_addr = {32'h600, 32'h500};
    @(posedge clk);
    #1;
    check("pre-reset grant", rr_grant, 2'b01);
    check("pre-reset s_addr", rr_s_addr, 32'h500);
    @(negedge clk);
    res_n = 1'b0;
    sv_drv = 1'b1;
    #1;
    check("async grant", rr_grant, 0);
    check("async s_en", rr_s_en, 0);
    check("async busy", rr_busy, 0);
    check("async m_valid", rr_m_valid, 0);
    check("async m_err", rr_m_err, 0);
    check("async m_rdata", rr_m_rdata, 0);
    check("async s_addr", rr_s_addr, 0);
    @(negedge clk);
    res_n = 1'b1;
    sv_drv = 1'b0;
    m_en = 2'b10;
    @(posedge clk);
    #1;
    check("post-reset grant", rr_grant, 2'b10);
    check("post-reset s_en", rr_s_en, 1);
    check("post-reset s_addr", rr_s_addr, 32'h600);
    check("post-reset m_valid", rr_m_valid, 0);
    check("post-reset m_err", rr_m_err, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
